pixel_loader: RTL and testbench
===============================

Name: pixel_loader

Overview:
- Upstream feeder for neurocore's data SRAM port.
- Accepts one MNIST image as an 8-bit pixel stream (valid/ready) and packs it into 32-bit words in neurocore's byte-lane order.
- Writes the words into data SRAM, then releases neurocore from reset so it can run inference on the loaded image.
- Holds the core in reset during every load, so the two never share the SRAM port.

Parameters:
- BASE_ADDR, 16'h0000: byte address of pixel 0 in data SRAM. Must be 4-aligned; bits [1:0] are ignored.
- N_PIXELS, 784: number of pixels per image, valid range 1..1023.
- CNT_W, 10: width of the pixel counter; must satisfy 2^CNT_W > N_PIXELS.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse: begin loading an image.
- pix_valid  in  1  pixel stream valid.
- pix_data  in  8  pixel value, unsigned.
- pix_ready  out  1  loader accepts pix_data this cycle.
- data_addr  out  16  SRAM byte address; word-aligned, bits [1:0]=0.
- data_din  out  32  SRAM write data.
- data_en  out  1  SRAM enable.
- data_we  out  4  SRAM byte write enables; bit 3 = bits [31:24].
- core_rst_n  out  1  active-low reset to neurocore.
- busy  out  1  high in LOAD or FLUSH.
- done  out  1  image fully written; core running.
- pix_count  out  CNT_W  number of pixels accepted in the current load.

Behaviour:
- All outputs are registered. After rst: state IDLE, and every output is 0, including core_rst_n (core held in reset).
- FSM states: IDLE -> LOAD on start. LOAD -> FLUSH on acceptance of pixel N_PIXELS. FLUSH -> DONE after one cycle. DONE -> LOAD on start.
- start is ignored in LOAD and FLUSH.
- Entry to LOAD clears pix_count, the lane index, the packing register and the word index; it also drives core_rst_n=0.
- LOAD: pix_ready=1.
  - A pixel is accepted when pix_valid & pix_ready.
  - Accepted pixel k (0-based) goes to lane k mod 4: lane 0 = bits [31:24], lane 1 = [23:16], lane 2 = [15:8], lane 3 = [7:0].
  - Throughput is 1 pixel/clk; no bubbles when pix_valid is held high.
- Write issue:
  - When lane 3 is accepted, or the final pixel is accepted, a write is issued in the next cycle: data_en=1, data_addr = BASE_ADDR + 4*word_index (mod 2^16), data_din = packed word.
  - data_we has a 1 for each filled lane. Unfilled lanes get din 0 and we 0; the last word may be partial.
  - The packing register is cleared and word_index increments in the same cycle the write is issued.
  - Acceptance of the next pixel continues in parallel with the write.
  - data_en=0 and data_we=0 in all other cycles.
- FLUSH:
  - pix_ready=0. The final write is issued in this cycle; exactly one write is ever issued in FLUSH.
- DONE:
  - done=1, core_rst_n=1, busy=0.
  - pix_count holds N_PIXELS.
  - No SRAM access; the port is owned by neurocore.
- pix_data is never sampled unless pix_valid & pix_ready. Pixel values are stored unmodified; neurocore does its own fixed-point alignment.
- rst mid-load: the FSM returns to IDLE next edge.
  - Any pending write is dropped, with no data_en that cycle.
  - core_rst_n=0 and the partial image is discarded.
  - A following start restarts at BASE_ADDR.
- Total writes per load = ceil(N_PIXELS/4). Latency with no gaps, start in cycle 0:
  - pixels accepted in cycles 1..N_PIXELS
  - FLUSH in cycle N_PIXELS+1
  - done=1 from cycle N_PIXELS+2.

Decomposition:
- def.h gains:
  - FSM encodings PL_IDLE/PL_LOAD/PL_FLUSH/PL_DONE and width PL_STAT_W;
  - DATA_IMG_BASE, so neurocore programs and the loader agree on the image address;
  - the lane-to-bit mapping constants shared with neurocore's byte load/store.
- One sub-module is natural: byte_packer.
  - Holds the lane index, 32-bit accumulator and we mask.
  - Inputs: push, byte, last, clear. Outputs: word_ready, word, mask.
- pixel_loader keeps the FSM, counters, address generation and output registers.

Test Plan:
- Reset: assert rst 3 cycles -> all outputs 0, core_rst_n=0, pix_ready=0, no data_en.
- Full image: N_PIXELS=784, start at cycle 0, pixel k = k mod 256 continuous.
  - Exactly 196 writes, each with data_we=4'b1111.
  - First write: addr 0x0000, din 0x00010203.
  - Last write: addr 0x030C, din 0x0C0D0E0F, issued in FLUSH at cycle 785.
  - done=1 and core_rst_n=1 at cycle 786.
- Partial last word: N_PIXELS=6, BASE_ADDR=16'h0100, pixels AA BB CC DD EE FF.
  - First write: addr 0x0100, din 0xAABBCCDD, we 4'b1111.
  - Second write: addr 0x0104, din 0xEEFF0000, we 4'b1100.
  - pix_count=6.
- Backpressure: pix_valid toggled every other cycle with random data -> identical write contents and addresses, no duplicate or missing writes, data_en never high in consecutive cycles.
- Reset mid-load: rst after 100 accepted pixels -> IDLE next cycle, no data_en, core_rst_n stays 0. A new start plus a full image produces a first write at BASE_ADDR.
- start handling:
  - start pulsed in LOAD -> ignored; pix_count and writes are unaffected.
  - start pulsed in DONE -> core_rst_n=0 and done=0 next cycle, and a second image reloads from BASE_ADDR.

Source files
------------

// File: rtl/pixel_loader_pkg.sv
// Shared definitions for the pixel loader: FSM encoding, image base address
// and the byte-lane mapping used by neurocore's byte load/store.
package pixel_loader_pkg;

    localparam int PL_STAT_W = 2;

    typedef enum logic [PL_STAT_W-1:0] {
        PL_IDLE  = 2'd0,
        PL_LOAD  = 2'd1,
        PL_FLUSH = 2'd2,
        PL_DONE  = 2'd3
    } pl_state_t;

    localparam logic [15:0] DATA_IMG_BASE = 16'h0000;

    // Lane 0 is the most significant byte, matching neurocore's big-endian lanes.
    function automatic logic [31:0] lane_insert(input logic [31:0] w,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  b);
        logic [31:0] r;
        r = w;
        case (lane)
            2'd0:    r[31:24] = b;
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            default: r[7:0]   = b;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] lane_we(input logic [1:0] lane);
        return 4'b1000 >> lane;
    endfunction

endpackage

// File: rtl/pixel_loader_byte_packer.sv
// Packs a byte stream into 32-bit words; flags a word when lane 3 or the
// final byte of the image is pushed, and restarts empty on the next byte.
module pixel_loader_byte_packer
    import pixel_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_push,
    input  logic        i_last,
    input  logic [7:0]  i_byte,
    output logic        o_word_ready,
    output logic [31:0] o_word,
    output logic [3:0]  o_mask
);

    logic [1:0]  r_lane;
    logic [31:0] r_acc;
    logic [3:0]  r_mask;

    always_comb begin
        o_word = r_acc;
        o_mask = r_mask;
        if (i_push) begin
            o_word = lane_insert(r_acc, r_lane, i_byte);
            o_mask = r_mask | lane_we(r_lane);
        end
    end

    assign o_word_ready = i_push & ((r_lane == 2'd3) | i_last);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_lane <= 2'd0;
            r_acc  <= 32'd0;
            r_mask <= 4'd0;
        end else if (i_push) begin
            if (o_word_ready) begin
                // The word leaves this cycle, so the next byte starts a fresh one.
                r_lane <= 2'd0;
                r_acc  <= 32'd0;
                r_mask <= 4'd0;
            end else begin
                r_lane <= r_lane + 2'd1;
                r_acc  <= o_word;
                r_mask <= o_mask;
            end
        end
    end

endmodule

// File: rtl/pixel_loader.sv
// Loads one image from an 8-bit pixel stream into neurocore's data SRAM,
// holding the core in reset while the SRAM port is in use.
module pixel_loader
    import pixel_loader_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = DATA_IMG_BASE,
    parameter int          N_PIXELS  = 784,
    parameter int          CNT_W     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pix_valid,
    input  logic [7:0]       pix_data,
    output logic             pix_ready,
    output logic [15:0]      data_addr,
    output logic [31:0]      data_din,
    output logic             data_en,
    output logic [3:0]       data_we,
    output logic             core_rst_n,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pix_count
);

    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(N_PIXELS - 1);
    localparam logic [15:0]      BASE_WORD = {BASE_ADDR[15:2], 2'b00};

    pl_state_t   r_state;
    logic [13:0] r_word_idx;

    logic        w_accept;
    logic        w_last;
    logic        w_clear;
    logic        w_word_ready;
    logic [31:0] w_word;
    logic [3:0]  w_mask;

    assign w_accept = pix_valid & pix_ready & (r_state == PL_LOAD);
    assign w_last   = (pix_count == LAST_IDX);
    assign w_clear  = start & ((r_state == PL_IDLE) | (r_state == PL_DONE));

    pixel_loader_byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_clear),
        .i_push       (w_accept),
        .i_last       (w_last),
        .i_byte       (pix_data),
        .o_word_ready (w_word_ready),
        .o_word       (w_word),
        .o_mask       (w_mask)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= PL_IDLE;
            r_word_idx <= 14'd0;
            pix_ready  <= 1'b0;
            data_addr  <= 16'd0;
            data_din   <= 32'd0;
            data_en    <= 1'b0;
            data_we    <= 4'd0;
            core_rst_n <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pix_count  <= '0;
        end else begin
            data_en <= 1'b0;
            data_we <= 4'd0;
            // A completed word only arises from an accepted pixel, i.e. in LOAD.
            if (w_word_ready) begin
                data_en    <= 1'b1;
                data_we    <= w_mask;
                data_din   <= w_word;
                data_addr  <= BASE_WORD + {r_word_idx, 2'b00};
                r_word_idx <= r_word_idx + 14'd1;
            end
            case (r_state)
                PL_IDLE, PL_DONE: begin
                    if (start) begin
                        r_state    <= PL_LOAD;
                        r_word_idx <= 14'd0;
                        pix_ready  <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        core_rst_n <= 1'b0;
                        pix_count  <= '0;
                    end
                end
                PL_LOAD: begin
                    if (w_accept) begin
                        pix_count <= pix_count + 1'b1;
                        if (w_last) begin
                            r_state   <= PL_FLUSH;
                            pix_ready <= 1'b0;
                        end
                    end
                end
                PL_FLUSH: begin
                    r_state    <= PL_DONE;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    core_rst_n <= 1'b1;
                end
                default: r_state <= PL_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_loader.sv
// Directed bench for pixel_loader: a 784-pixel instance for full-image,
// backpressure and reset cases, and a 6-pixel instance driven from a table.
module tb_pixel_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 784-pixel instance, base 0
    logic        start_a = 0, valid_a = 0;
    logic [7:0]  data_a = 0;
    logic        ready_a, en_a, crst_a, busy_a, done_a;
    logic [15:0] addr_a;
    logic [31:0] din_a;
    logic [3:0]  we_a;
    logic [9:0]  cnt_a;

    // 6-pixel instance, base 0x0100
    logic        start_b = 0, valid_b = 0;
    logic [7:0]  data_b = 0;
    logic        ready_b, en_b, crst_b, busy_b, done_b;
    logic [15:0] addr_b;
    logic [31:0] din_b;
    logic [3:0]  we_b;
    logic [9:0]  cnt_b;

    pixel_loader #(.BASE_ADDR(16'h0000), .N_PIXELS(784), .CNT_W(10)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .pix_valid(valid_a), .pix_data(data_a),
        .pix_ready(ready_a), .data_addr(addr_a), .data_din(din_a), .data_en(en_a),
        .data_we(we_a), .core_rst_n(crst_a), .busy(busy_a), .done(done_a), .pix_count(cnt_a)
    );

    pixel_loader #(.BASE_ADDR(16'h0100), .N_PIXELS(6), .CNT_W(10)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .pix_valid(valid_b), .pix_data(data_b),
        .pix_ready(ready_b), .data_addr(addr_b), .data_din(din_b), .data_en(en_b),
        .data_we(we_b), .core_rst_n(crst_b), .busy(busy_b), .done(done_b), .pix_count(cnt_b)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        start;
        logic        valid;
        logic [7:0]  data;
        logic        e_ready;
        logic        e_en;
        logic [15:0] e_addr;
        logic [31:0] e_din;
        logic [3:0]  e_we;
        logic        e_busy;
        logic        e_done;
        logic        e_crst;
        logic [9:0]  e_cnt;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(input logic s, input logic v, input logic [7:0] d,
                                input logic rdy, input logic en, input logic [15:0] a,
                                input logic [31:0] din, input logic [3:0] we,
                                input logic bsy, input logic dn, input logic cr,
                                input logic [9:0] cnt);
        vec_t r;
        r.start = s;  r.valid = v;  r.data = d;
        r.e_ready = rdy; r.e_en = en; r.e_addr = a; r.e_din = din; r.e_we = we;
        r.e_busy = bsy; r.e_done = dn; r.e_crst = cr; r.e_cnt = cnt;
        return r;
    endfunction

    // Write monitor state for dut_a
    logic [7:0]  img [784];
    int          wr_idx;
    int          cyc_no;
    int          last_wr_cyc;
    logic        prev_en;
    logic [15:0] first_addr, last_addr;
    logic [31:0] first_din, last_din;

    task automatic cyc_a(input logic s, input logic v, input logic [7:0] d);
        @(negedge clk);
        start_a = s;
        valid_a = v;
        data_a  = d;
        @(posedge clk);
        #1;
        cyc_no++;
        if (en_a) begin
            chk("en_gap", 32'(prev_en), 32'd0);
            if (wr_idx >= 196) begin
                chk("extra_write", 32'(wr_idx), 32'd195);
            end else begin
                chk("wr_addr", 32'(addr_a), 32'(4 * wr_idx));
                chk("wr_din", din_a, {img[4*wr_idx], img[4*wr_idx+1], img[4*wr_idx+2], img[4*wr_idx+3]});
                chk("wr_we", 32'(we_a), 32'hF);
            end
            if (wr_idx == 0) begin
                first_addr = addr_a;
                first_din  = din_a;
            end
            last_addr   = addr_a;
            last_din    = din_a;
            last_wr_cyc = cyc_no;
            wr_idx++;
        end
        prev_en = en_a;
    endtask

    // Start at cycle 0, then one pixel per cycle from cycle 1.
    task automatic load_cont();
        wr_idx  = 0;
        cyc_no  = 0;
        prev_en = 1'b0;
        cyc_a(1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 784; k++) cyc_a(1'b0, 1'b1, img[k]);
    endtask

    initial begin
        tbl[0]  = mk(1, 0, 8'h00, 1, 0, 16'h0000, 32'h0,        4'h0, 1, 0, 0, 10'd0);
        tbl[1]  = mk(0, 1, 8'hAA, 1, 0, 16'h0000, 32'h0,        4'h0, 1, 0, 0, 10'd1);
        tbl[2]  = mk(0, 1, 8'hBB, 1, 0, 16'h0000, 32'h0,        4'h0, 1, 0, 0, 10'd2);
        tbl[3]  = mk(0, 1, 8'hCC, 1, 0, 16'h0000, 32'h0,        4'h0, 1, 0, 0, 10'd3);
        tbl[4]  = mk(0, 1, 8'hDD, 1, 1, 16'h0100, 32'hAABBCCDD, 4'hF, 1, 0, 0, 10'd4);
        tbl[5]  = mk(0, 0, 8'h5A, 1, 0, 16'h0000, 32'h0,        4'h0, 1, 0, 0, 10'd4);
        tbl[6]  = mk(0, 1, 8'hEE, 1, 0, 16'h0000, 32'h0,        4'h0, 1, 0, 0, 10'd5);
        tbl[7]  = mk(0, 1, 8'hFF, 0, 1, 16'h0104, 32'hEEFF0000, 4'hC, 1, 0, 0, 10'd6);
        tbl[8]  = mk(0, 1, 8'h11, 0, 0, 16'h0000, 32'h0,        4'h0, 0, 1, 1, 10'd6);
        tbl[9]  = mk(1, 0, 8'h00, 1, 0, 16'h0000, 32'h0,        4'h0, 1, 0, 0, 10'd0);
        tbl[10] = mk(0, 1, 8'h01, 1, 0, 16'h0000, 32'h0,        4'h0, 1, 0, 0, 10'd1);
        tbl[11] = mk(1, 1, 8'h02, 1, 0, 16'h0000, 32'h0,        4'h0, 1, 0, 0, 10'd2);
        tbl[12] = mk(0, 1, 8'h03, 1, 0, 16'h0000, 32'h0,        4'h0, 1, 0, 0, 10'd3);
        tbl[13] = mk(0, 1, 8'h04, 1, 1, 16'h0100, 32'h01020304, 4'hF, 1, 0, 0, 10'd4);
        tbl[14] = mk(0, 1, 8'h05, 1, 0, 16'h0000, 32'h0,        4'h0, 1, 0, 0, 10'd5);
        tbl[15] = mk(0, 1, 8'h06, 0, 1, 16'h0104, 32'h05060000, 4'hC, 1, 0, 0, 10'd6);
        tbl[16] = mk(0, 0, 8'h00, 0, 0, 16'h0000, 32'h0,        4'h0, 0, 1, 1, 10'd6);

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_ctrl", 32'({ready_a, en_a, we_a, crst_a, busy_a, done_a, cnt_a}), 32'd0);
        chk("rst_a_addr", 32'(addr_a), 32'd0);
        chk("rst_a_din", din_a, 32'd0);
        chk("rst_b_ctrl", 32'({ready_b, en_b, we_b, crst_b, busy_b, done_b, cnt_b}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Six-pixel image with a partial last word, reloaded after DONE
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            start_b = tbl[i].start;
            valid_b = tbl[i].valid;
            data_b  = tbl[i].data;
            @(posedge clk);
            #1;
            chk($sformatf("b%0d_ready", i), 32'(ready_b), 32'(tbl[i].e_ready));
            chk($sformatf("b%0d_en", i), 32'(en_b), 32'(tbl[i].e_en));
            chk($sformatf("b%0d_we", i), 32'(we_b), 32'(tbl[i].e_we));
            chk($sformatf("b%0d_busy", i), 32'(busy_b), 32'(tbl[i].e_busy));
            chk($sformatf("b%0d_done", i), 32'(done_b), 32'(tbl[i].e_done));
            chk($sformatf("b%0d_crst", i), 32'(crst_b), 32'(tbl[i].e_crst));
            chk($sformatf("b%0d_cnt", i), 32'(cnt_b), 32'(tbl[i].e_cnt));
            if (tbl[i].e_en) begin
                chk($sformatf("b%0d_addr", i), 32'(addr_b), 32'(tbl[i].e_addr));
                chk($sformatf("b%0d_din", i), din_b, tbl[i].e_din);
            end
        end
        @(negedge clk);
        start_b = 1'b0;
        valid_b = 1'b0;

        // Full continuous image, pixel k = k mod 256
        for (int k = 0; k < 784; k++) img[k] = 8'(k);
        load_cont();
        chk("full_last_cycle", 32'(last_wr_cyc), 32'd785);
        chk("full_ready_flush", 32'(ready_a), 32'd0);
        cyc_a(1'b0, 1'b0, 8'h00);
        chk("full_writes", 32'(wr_idx), 32'd196);
        chk("full_first_addr", 32'(first_addr), 32'h0000);
        chk("full_first_din", first_din, 32'h00010203);
        chk("full_last_addr", 32'(last_addr), 32'h030C);
        chk("full_last_din", last_din, 32'h0C0D0E0F);
        chk("full_done_c786", 32'({done_a, crst_a, busy_a}), 32'b110);
        chk("full_cnt", 32'(cnt_a), 32'd784);

        // Start from DONE: core back in reset, then a backpressured random image
        for (int k = 0; k < 784; k++) img[k] = 8'($urandom);
        wr_idx  = 0;
        cyc_no  = 0;
        prev_en = 1'b0;
        cyc_a(1'b1, 1'b0, 8'h00);
        chk("restart_crst", 32'(crst_a), 32'd0);
        chk("restart_done", 32'(done_a), 32'd0);
        begin
            int k = 0;
            logic v = 1'b1;
            for (int g = 0; g < 4000 && k < 784; g++) begin
                if (v && ready_a) begin
                    cyc_a(1'b0, 1'b1, img[k]);
                    k++;
                end else begin
                    cyc_a(1'b0, v, 8'($urandom));
                end
                v = ~v;
            end
            chk("bp_all_accepted", 32'(k), 32'd784);
        end
        for (int g = 0; g < 10 && !done_a; g++) cyc_a(1'b0, 1'b0, 8'h00);
        chk("bp_done", 32'(done_a), 32'd1);
        chk("bp_writes", 32'(wr_idx), 32'd196);
        chk("bp_cnt", 32'(cnt_a), 32'd784);

        // Reset coinciding with the acceptance of pixel 100 (a lane-3 pixel)
        for (int k = 0; k < 784; k++) img[k] = 8'(k * 7);
        wr_idx  = 0;
        cyc_no  = 0;
        prev_en = 1'b0;
        cyc_a(1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 99; k++) cyc_a(1'b0, 1'b1, img[k]);
        rst = 1'b1;
        cyc_a(1'b0, 1'b1, img[99]);
        chk("mid_rst_en", 32'(en_a), 32'd0);
        chk("mid_rst_ctrl", 32'({ready_a, busy_a, done_a, crst_a}), 32'd0);
        chk("mid_rst_cnt", 32'(cnt_a), 32'd0);
        chk("mid_rst_writes", 32'(wr_idx), 32'd24);
        rst = 1'b0;
        cyc_a(1'b0, 1'b0, 8'h00);
        chk("mid_rst_idle_crst", 32'({crst_a, busy_a}), 32'd0);
        for (int k = 0; k < 784; k++) img[k] = 8'(255 - k);
        load_cont();
        cyc_a(1'b0, 1'b0, 8'h00);
        chk("after_rst_writes", 32'(wr_idx), 32'd196);
        chk("after_rst_first_addr", 32'(first_addr), 32'h0000);
        chk("after_rst_first_din", first_din, 32'hFFFEFDFC);
        chk("after_rst_done", 32'({done_a, crst_a}), 32'b11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
